decodificador_tramas_uart: RTL

//  Consumer stage directly downstream of the UART receiver: takes each received byte (1-cycle strobe + data),

---
 rtl/decodificador_tramas_uart_pkg.sv | 23 ++
 rtl/decodificador_tramas_uart_if.sv | 28 ++
 rtl/decodificador_tramas_uart_temporizador.sv | 35 +++
 rtl/decodificador_tramas_uart.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/decodificador_tramas_uart_pkg.sv
// Shared types for the UART frame decoder: FSM states, error codes and the default start-of-frame byte.
package paquete_tramas_uart;

  localparam logic [7:0] CABECERA_DEF = 8'hA5;

  typedef enum logic [2:0] {
    BUSCAR_CABECERA,
    LEER_LONGITUD,
    LEER_CARGA,
    LEER_CHECKSUM,
    ENTREGAR
  } estado_t;

  // Exactly one error source can fire per cycle, so a single code feeds all pulses.
  typedef enum logic [2:0] {
    ERR_NINGUNO,
    ERR_CHECKSUM,
    ERR_LONGITUD,
    ERR_TIMEOUT,
    ERR_PERDIDO
  } codigo_error_t;

endpackage

// File: rtl/decodificador_tramas_uart_if.sv
// Byte-in / payload-out bundle between the UART receiver, the frame decoder and the command logic.
interface decodificador_tramas_uart_if #(
  parameter int ANCHO_DATO = 8
);
  logic                  datoValido;
  logic [ANCHO_DATO-1:0] datoRecibido;
  logic                  salidaListo;
  logic                  salidaValido;
  logic [ANCHO_DATO-1:0] salidaDato;
  logic                  salidaUltimo;
  logic                  errorChecksum;
  logic                  errorLongitud;
  logic                  errorTimeout;
  logic                  bytePerdido;
  logic [7:0]            contadorErrores;

  modport master (
    output datoValido, datoRecibido, salidaListo,
    input  salidaValido, salidaDato, salidaUltimo,
    input  errorChecksum, errorLongitud, errorTimeout, bytePerdido, contadorErrores
  );

  modport slave (
    input  datoValido, datoRecibido, salidaListo,
    output salidaValido, salidaDato, salidaUltimo,
    output errorChecksum, errorLongitud, errorTimeout, bytePerdido, contadorErrores
  );
endinterface

// File: rtl/decodificador_tramas_uart_temporizador.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and flags the final allowed cycle.
module temporizador_inactividad #(
  parameter int CICLOS_TIMEOUT = 104170
) (
  input  logic reloj,
  input  logic reinicio,
  input  logic limpiar,
  input  logic habilitar,
  output logic expirado
);
  localparam int ANCHO = $clog2(CICLOS_TIMEOUT);
  localparam logic [ANCHO-1:0] LIMITE = ANCHO'(CICLOS_TIMEOUT - 1);
  localparam logic [ANCHO-1:0] UNO = ANCHO'(1);

  logic [ANCHO-1:0] cuenta_q, cuenta_d;

  // A clear in the expiry cycle suppresses the expiry, so an arriving byte wins.
  always_comb begin
    expirado = habilitar && !limpiar && (cuenta_q == LIMITE);
    cuenta_d = cuenta_q;
    if (limpiar || expirado) begin
      cuenta_d = '0;
    end else if (habilitar) begin
      cuenta_d = cuenta_q + UNO;
    end
  end

  always_ff @(posedge reloj) begin
    if (!reinicio) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end
endmodule

// File: rtl/decodificador_tramas_uart.sv
// Frames received UART bytes as [CABECERA][LEN][payload][CHK], checks them and streams
// the buffered payload downstream with valid/ready/last; bad frames raise error pulses.
module decodificador_tramas_uart
  import paquete_tramas_uart::*;
#(
  parameter int                    ANCHO_DATO     = 8,
  parameter int                    MAX_CARGA      = 16,
  parameter logic [ANCHO_DATO-1:0] CABECERA       = CABECERA_DEF,
  parameter int                    CICLOS_TIMEOUT = 104170
) (
  input logic                      reloj,
  input logic                      reinicio,
  decodificador_tramas_uart_if.slave bus
);
  localparam int ANCHO_IDX = $clog2(MAX_CARGA + 1);
  localparam int ANCHO_PTR = $clog2(MAX_CARGA);
  localparam logic [ANCHO_DATO-1:0] LEN_MAX = ANCHO_DATO'(MAX_CARGA);
  localparam logic [ANCHO_IDX-1:0]  UNO     = ANCHO_IDX'(1);

  estado_t                 estado_q, estado_d;
  codigo_error_t           codigo;
  logic [ANCHO_IDX-1:0]    indice_q, indice_d, longitud_q, longitud_d, siguiente;
  logic [ANCHO_DATO-1:0]   chk_q, chk_d;
  logic [ANCHO_DATO-1:0]   buffer_q [MAX_CARGA];
  logic [ANCHO_DATO-1:0]   buffer_d [MAX_CARGA];
  logic                    valido_q, valido_d, ultimo_q, ultimo_d;
  logic [ANCHO_DATO-1:0]   dato_q, dato_d;
  logic                    err_chk_q, err_chk_d, err_len_q, err_len_d;
  logic                    err_tmo_q, err_tmo_d, perdido_q, perdido_d;
  logic [7:0]              contador_q, contador_d;
  logic                    limpiar, habilitar, expirado;

  // Holding the timer clear while searching means every frame starts its gap count from zero.
  assign limpiar   = bus.datoValido || (estado_q == BUSCAR_CABECERA);
  assign habilitar = (estado_q == LEER_LONGITUD) || (estado_q == LEER_CARGA) ||
                     (estado_q == LEER_CHECKSUM);

  temporizador_inactividad #(.CICLOS_TIMEOUT(CICLOS_TIMEOUT)) u_temporizador (
    .reloj    (reloj),
    .reinicio (reinicio),
    .limpiar  (limpiar),
    .habilitar(habilitar),
    .expirado (expirado)
  );

  always_comb begin
    estado_d   = estado_q;
    indice_d   = indice_q;
    longitud_d = longitud_q;
    chk_d      = chk_q;
    buffer_d   = buffer_q;
    valido_d   = valido_q;
    dato_d     = dato_q;
    ultimo_d   = ultimo_q;
    codigo     = ERR_NINGUNO;
    siguiente  = indice_q + UNO;
    case (estado_q)
      BUSCAR_CABECERA: begin
        if (bus.datoValido && bus.datoRecibido == CABECERA) begin
          estado_d = LEER_LONGITUD;
        end
      end
      LEER_LONGITUD: begin
        if (bus.datoValido) begin
          chk_d = bus.datoRecibido;
          if (bus.datoRecibido == '0 || bus.datoRecibido > LEN_MAX) begin
            codigo   = ERR_LONGITUD;
            estado_d = BUSCAR_CABECERA;
          end else begin
            longitud_d = ANCHO_IDX'(bus.datoRecibido);
            indice_d   = '0;
            estado_d   = LEER_CARGA;
          end
        end else if (expirado) begin
          codigo   = ERR_TIMEOUT;
          estado_d = BUSCAR_CABECERA;
        end
      end
      LEER_CARGA: begin
        if (bus.datoValido) begin
          buffer_d[indice_q[ANCHO_PTR-1:0]] = bus.datoRecibido;
          chk_d = chk_q ^ bus.datoRecibido;
          if (indice_q == longitud_q - UNO) begin
            estado_d = LEER_CHECKSUM;
          end else begin
            indice_d = siguiente;
          end
        end else if (expirado) begin
          codigo   = ERR_TIMEOUT;
          estado_d = BUSCAR_CABECERA;
        end
      end
      LEER_CHECKSUM: begin
        if (bus.datoValido) begin
          if (bus.datoRecibido == chk_q) begin
            estado_d = ENTREGAR;
            indice_d = '0;
            valido_d = 1'b1;
            dato_d   = buffer_q[0];
            ultimo_d = (longitud_q == UNO);
          end else begin
            codigo   = ERR_CHECKSUM;
            estado_d = BUSCAR_CABECERA;
          end
        end else if (expirado) begin
          codigo   = ERR_TIMEOUT;
          estado_d = BUSCAR_CABECERA;
        end
      end
      ENTREGAR: begin
        if (bus.datoValido) begin
          codigo = ERR_PERDIDO;
        end
        if (valido_q && bus.salidaListo) begin
          if (ultimo_q) begin
            valido_d = 1'b0;
            ultimo_d = 1'b0;
            dato_d   = '0;
            estado_d = BUSCAR_CABECERA;
          end else begin
            indice_d = siguiente;
            dato_d   = buffer_q[siguiente[ANCHO_PTR-1:0]];
            ultimo_d = (siguiente == longitud_q - UNO);
          end
        end
      end
      default: estado_d = BUSCAR_CABECERA;
    endcase
    err_chk_d  = (codigo == ERR_CHECKSUM);
    err_len_d  = (codigo == ERR_LONGITUD);
    err_tmo_d  = (codigo == ERR_TIMEOUT);
    perdido_d  = (codigo == ERR_PERDIDO);
    contador_d = contador_q;
    if (codigo != ERR_NINGUNO && contador_q != 8'hFF) begin
      contador_d = contador_q + 8'd1;
    end
  end

  always_ff @(posedge reloj) begin
    if (!reinicio) begin
      estado_q   <= BUSCAR_CABECERA;
      indice_q   <= '0;
      longitud_q <= '0;
      chk_q      <= '0;
      valido_q   <= 1'b0;
      dato_q     <= '0;
      ultimo_q   <= 1'b0;
      err_chk_q  <= 1'b0;
      err_len_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
      perdido_q  <= 1'b0;
      contador_q <= '0;
    end else begin
      estado_q   <= estado_d;
      indice_q   <= indice_d;
      longitud_q <= longitud_d;
      chk_q      <= chk_d;
      valido_q   <= valido_d;
      dato_q     <= dato_d;
      ultimo_q   <= ultimo_d;
      err_chk_q  <= err_chk_d;
      err_len_q  <= err_len_d;
      err_tmo_q  <= err_tmo_d;
      perdido_q  <= perdido_d;
      contador_q <= contador_d;
    end
  end

  // Payload storage needs no reset: it is only read after a full frame has been written.
  always_ff @(posedge reloj) begin
    buffer_q <= buffer_d;
  end

  assign bus.salidaValido    = valido_q;
  assign bus.salidaDato      = dato_q;
  assign bus.salidaUltimo    = ultimo_q;
  assign bus.errorChecksum   = err_chk_q;
  assign bus.errorLongitud   = err_len_q;
  assign bus.errorTimeout    = err_tmo_q;
  assign bus.bytePerdido     = perdido_q;
  assign bus.contadorErrores = contador_q;
endmodule
